road_density_sensor: RTL and testbench

- Front-end stage feeding the level-1 traffic-light controller: converts raw vehicle-detector loop signals on four roads into the 3-bit thermometer density codes S1..S4 that the controller consumes.
- Keeps a per-road occupancy count from arrival/departure loops and maps it to EMPTY/LESS/MORE/FULL with hysteresis, so the controller never sees code chatter.

---
 rtl/road_density_sensor.sv | 171 +++++++++++++++++
 tb/tb_road_density_sensor.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/road_density_sensor.sv
// ============================================================================
// Module   : road_density_sensor
// Function : Per-road vehicle occupancy counters with hysteretic density codes
//            (EMPTY/LESS/MORE/FULL) for four roads. Optional DENSITY_ERR_EN
//            adds sticky drop flags (err) and a flag/occupancy clear (err_clr).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module road_density_sensor #(
    parameter int CNT_W   = 5,
    parameter int LESS_TH = 1,
    parameter int MORE_TH = 6,
    parameter int FULL_TH = 12,
    parameter int HYST    = 2
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [3:0]           arr,
    input  logic [3:0]           dep,
`ifdef DENSITY_ERR_EN
    input  logic                 err_clr,
    output logic [3:0]           err,
`endif
    output logic [2:0]           S1,
    output logic [2:0]           S2,
    output logic [2:0]           S3,
    output logic [2:0]           S4,
    output logic [4*CNT_W-1:0]   occ_all
);

    localparam logic [CNT_W-1:0] c_OCC_MAX   = '1;
    localparam logic [CNT_W-1:0] c_LESS_TH   = CNT_W'(LESS_TH);
    localparam logic [CNT_W-1:0] c_MORE_TH   = CNT_W'(MORE_TH);
    localparam logic [CNT_W-1:0] c_FULL_TH   = CNT_W'(FULL_TH);
    localparam logic [CNT_W-1:0] c_MORE_FALL = CNT_W'(MORE_TH - HYST);
    localparam logic [CNT_W-1:0] c_FULL_FALL = CNT_W'(FULL_TH - HYST);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_LESS  = 2'd1;
    localparam logic [1:0] c_ST_MORE  = 2'd2;
    localparam logic [1:0] c_ST_FULL  = 2'd3;

    localparam logic [2:0] c_CODE_EMPTY = 3'b000;
    localparam logic [2:0] c_CODE_LESS  = 3'b001;
    localparam logic [2:0] c_CODE_MORE  = 3'b011;
    localparam logic [2:0] c_CODE_FULL  = 3'b111;

    logic [3:0]  r_arr_hist;
    logic [3:0]  r_dep_hist;
    logic [3:0]  w_arr_rise;
    logic [3:0]  w_dep_rise;
    logic        w_occ_clr;
    logic [11:0] w_codes;

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_arr_hist <= 4'b0000;
            r_dep_hist <= 4'b0000;
        end else begin
            r_arr_hist <= arr;
            r_dep_hist <= dep;
        end
    end

    assign w_arr_rise = arr & ~r_arr_hist;
    assign w_dep_rise = dep & ~r_dep_hist;

`ifdef DENSITY_ERR_EN
    assign w_occ_clr = err_clr;
`else
    assign w_occ_clr = 1'b0;
`endif

    generate
        for (genvar i = 0; i < 4; i++) begin : g_road
            logic [CNT_W-1:0] r_occ;
            logic [1:0]       r_state;
            logic [1:0]       w_state_nxt;
            logic [2:0]       w_code;
            logic             w_inc;
            logic             w_dec;

            // Coincident arrival and departure cancel, so only lone events move the count.
            assign w_inc = w_arr_rise[i] & ~w_dep_rise[i];
            assign w_dec = w_dep_rise[i] & ~w_arr_rise[i];

            always_ff @(posedge clock) begin
                if (!clear) begin
                    r_occ <= '0;
                end else if (w_occ_clr) begin
                    r_occ <= '0;
                end else if (w_inc && (r_occ != c_OCC_MAX)) begin
                    r_occ <= r_occ + CNT_W'(1);
                end else if (w_dec && (r_occ != '0)) begin
                    r_occ <= r_occ - CNT_W'(1);
                end
            end

            always_ff @(posedge clock) begin
                if (!clear) begin
                    r_state <= c_ST_EMPTY;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // Level moves at most one step per clock, judged on the registered count.
            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    c_ST_EMPTY: begin
                        if (r_occ >= c_LESS_TH) w_state_nxt = c_ST_LESS;
                    end
                    c_ST_LESS: begin
                        if (r_occ >= c_MORE_TH)  w_state_nxt = c_ST_MORE;
                        else if (r_occ == '0)    w_state_nxt = c_ST_EMPTY;
                    end
                    c_ST_MORE: begin
                        if (r_occ >= c_FULL_TH)       w_state_nxt = c_ST_FULL;
                        else if (r_occ < c_MORE_FALL) w_state_nxt = c_ST_LESS;
                    end
                    c_ST_FULL: begin
                        if (r_occ < c_FULL_FALL) w_state_nxt = c_ST_MORE;
                    end
                    default: w_state_nxt = c_ST_EMPTY;
                endcase
            end

            always_comb begin
                w_code = c_CODE_EMPTY;
                case (r_state)
                    c_ST_LESS: w_code = c_CODE_LESS;
                    c_ST_MORE: w_code = c_CODE_MORE;
                    c_ST_FULL: w_code = c_CODE_FULL;
                    default:   w_code = c_CODE_EMPTY;
                endcase
            end

            assign w_codes[i*3 +: 3]          = w_code;
            assign occ_all[i*CNT_W +: CNT_W]  = r_occ;

`ifdef DENSITY_ERR_EN
            logic r_err;
            logic w_drop;

            assign w_drop = (w_inc && (r_occ == c_OCC_MAX)) || (w_dec && (r_occ == '0));

            always_ff @(posedge clock) begin
                if (!clear) begin
                    r_err <= 1'b0;
                end else if (err_clr) begin
                    r_err <= 1'b0;
                end else if (w_drop) begin
                    r_err <= 1'b1;
                end
            end

            assign err[i] = r_err;
`endif
        end
    endgenerate

    assign S1 = w_codes[2:0];
    assign S2 = w_codes[5:3];
    assign S3 = w_codes[8:6];
    assign S4 = w_codes[11:9];

endmodule

`default_nettype wire

// File: tb/tb_road_density_sensor.sv
// ============================================================================
// Module   : tb_road_density_sensor
// Function : Scoreboard bench for road_density_sensor with a behavioural
//            occupancy/level reference model; honours DENSITY_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_road_density_sensor;

    localparam int CNT_W   = 5;
    localparam int LESS_TH = 1;
    localparam int MORE_TH = 6;
    localparam int FULL_TH = 12;
    localparam int HYST    = 2;
    localparam int OCC_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4*CNT_W-1:0] occ;
        logic [11:0]        s;
        logic [3:0]         err;
    } exp_t;

    logic               clk;
    logic               clear;
    logic [3:0]         arr;
    logic [3:0]         dep;
    logic [2:0]         S1, S2, S3, S4;
    logic [4*CNT_W-1:0] occ_all;
`ifdef DENSITY_ERR_EN
    logic               err_clr;
    logic [3:0]         err;
`endif

    road_density_sensor #(
        .CNT_W   (CNT_W),
        .LESS_TH (LESS_TH),
        .MORE_TH (MORE_TH),
        .FULL_TH (FULL_TH),
        .HYST    (HYST)
    ) dut (
        .clock   (clk),
        .clear   (clear),
        .arr     (arr),
        .dep     (dep),
`ifdef DENSITY_ERR_EN
        .err_clr (err_clr),
        .err     (err),
`endif
        .S1      (S1),
        .S2      (S2),
        .S3      (S3),
        .S4      (S4),
        .occ_all (occ_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       sb_q[$];

    int         m_occ[4];
    int         m_lvl[4];
    logic [3:0] m_err;
    logic [3:0] m_pa;
    logic [3:0] m_pd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] level_code(input int lvl);
        logic [2:0] ones;
        ones = 3'b111;
        return ones >> (3 - lvl);
    endfunction

    // One clock of the reference: level judged on the count before this edge.
    task automatic model_edge(input logic [3:0] a, input logic [3:0] d, input logic c, input logic ec);
        exp_t e;
        if (!c) begin
            for (int i = 0; i < 4; i++) begin
                m_occ[i] = 0;
                m_lvl[i] = 0;
            end
            m_err = 4'b0000;
            m_pa  = 4'b0000;
            m_pd  = 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                bit ra, rd;
                int o;
                ra = a[i] && !m_pa[i];
                rd = d[i] && !m_pd[i];
                o  = m_occ[i];
                case (m_lvl[i])
                    0: if (o >= LESS_TH) m_lvl[i] = 1;
                    1: if (o >= MORE_TH) m_lvl[i] = 2; else if (o == 0) m_lvl[i] = 0;
                    2: if (o >= FULL_TH) m_lvl[i] = 3; else if (o < MORE_TH - HYST) m_lvl[i] = 1;
                    default: if (o < FULL_TH - HYST) m_lvl[i] = 2;
                endcase
`ifdef DENSITY_ERR_EN
                if (ec) begin
                    m_occ[i] = 0;
                    m_err[i] = 1'b0;
                end else
`endif
                if (ra && !rd) begin
                    if (o == OCC_MAX) m_err[i] = 1'b1;
                    else m_occ[i] = o + 1;
                end else if (rd && !ra) begin
                    if (o == 0) m_err[i] = 1'b1;
                    else m_occ[i] = o - 1;
                end
            end
            m_pa = a;
            m_pd = d;
        end
        for (int i = 0; i < 4; i++) begin
            e.occ[i*CNT_W +: CNT_W] = CNT_W'(m_occ[i]);
            e.s[i*3 +: 3]           = level_code(m_lvl[i]);
        end
        e.err = m_err;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] d, input logic c, input logic ec);
        @(negedge clk);
        arr   = a;
        dep   = d;
        clear = c;
`ifdef DENSITY_ERR_EN
        err_clr = ec;
`endif
        model_edge(a, d, c, ec);
    endtask

    task automatic pulses(input logic [3:0] am, input logic [3:0] dm, input int n);
        for (int k = 0; k < n; k++) begin
            step(am, dm, 1'b1, 1'b0);
            step(4'b0000, 4'b0000, 1'b1, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    endtask

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    // Monitor: the DUT presents a fresh state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("occ_all", 32'(occ_all), 32'(e.occ));
                check("S1", 32'(S1), 32'(e.s[2:0]));
                check("S2", 32'(S2), 32'(e.s[5:3]));
                check("S3", 32'(S3), 32'(e.s[8:6]));
                check("S4", 32'(S4), 32'(e.s[11:9]));
`ifdef DENSITY_ERR_EN
                check("err", 32'(err), 32'(e.err));
`endif
            end
        end
    end

    initial begin
        clear = 1'b0;
        arr   = 4'b0000;
        dep   = 4'b0000;
`ifdef DENSITY_ERR_EN
        err_clr = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            m_occ[i] = 0;
            m_lvl[i] = 0;
        end
        m_err = 4'b0000;
        m_pa  = 4'b0000;
        m_pd  = 4'b0000;

        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        idle(3);
        settle();
        check("idle_occ_all", 32'(occ_all), 32'd0);
        check("idle_S1", 32'(S1), 32'd0);

        pulses(4'b0001, 4'b0000, 6);
        idle(2);
        settle();
        check("rise_occ1", 32'(occ_all[0 +: CNT_W]), 32'd6);
        check("rise_S1", 32'(S1), 32'b011);

        pulses(4'b0000, 4'b0001, 2);
        idle(2);
        settle();
        check("hyst_S1_at4", 32'(S1), 32'b011);
        pulses(4'b0000, 4'b0001, 1);
        idle(2);
        settle();
        check("hyst_S1_at3", 32'(S1), 32'b001);

        pulses(4'b0100, 4'b0000, 12);
        idle(2);
        settle();
        check("hyst_S3_at12", 32'(S3), 32'b111);
        pulses(4'b0000, 4'b0100, 2);
        idle(2);
        settle();
        check("hyst_S3_at10", 32'(S3), 32'b111);
        pulses(4'b0000, 4'b0100, 1);
        idle(2);
        settle();
        check("hyst_S3_at9", 32'(S3), 32'b011);

        for (int k = 0; k < 10; k++) step(4'b0010, 4'b0000, 1'b1, 1'b0);
        idle(1);
        settle();
        check("held_occ2", 32'(occ_all[CNT_W +: CNT_W]), 32'd1);

        pulses(4'b0000, 4'b0100, 4);
        pulses(4'b0100, 4'b0100, 1);
        settle();
        check("simul_occ3", 32'(occ_all[2*CNT_W +: CNT_W]), 32'd5);

        pulses(4'b1111, 4'b0000, 1);
        settle();
        check("all_occ1", 32'(occ_all[0 +: CNT_W]), 32'd4);
        check("all_occ4", 32'(occ_all[3*CNT_W +: CNT_W]), 32'd1);

        pulses(4'b0000, 4'b1000, 2);
        idle(2);
        settle();
        check("floor_occ4", 32'(occ_all[3*CNT_W +: CNT_W]), 32'd0);
        check("floor_S4", 32'(S4), 32'd0);
`ifdef DENSITY_ERR_EN
        check("floor_err3", 32'(err[3]), 32'd1);
`endif

        pulses(4'b0001, 4'b0000, 35);
        idle(4);
        settle();
        check("sat_occ1", 32'(occ_all[0 +: CNT_W]), 32'd31);
        check("sat_S1", 32'(S1), 32'b111);
`ifdef DENSITY_ERR_EN
        check("sat_err0", 32'(err[0]), 32'd1);
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        settle();
        check("errclr_err", 32'(err), 32'd0);
        check("errclr_occ1", 32'(occ_all[0 +: CNT_W]), 32'd0);
        idle(4);
        pulses(4'b0001, 4'b0000, 20);
        idle(3);
`endif

        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        settle();
        check("midrst_occ", 32'(occ_all), 32'd0);
        check("midrst_S1", 32'(S1), 32'd0);

        for (int k = 0; k < 800; k++) begin
            logic [3:0] a, d;
            logic       c, ec;
            for (int i = 0; i < 4; i++) begin
                a[i] = ($urandom_range(0, 99) < 40);
                d[i] = ($urandom_range(0, 99) < 22);
            end
            c  = ($urandom_range(0, 299) != 0);
            ec = ($urandom_range(0, 149) == 0);
            step(a, d, c, ec);
        end
        idle(3);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
